// File: rtl/urna_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : urna_pkg
//  Description : Shared types and constants for the voter-session sequencer:
//                session state encoding, digit width, buffer depth and the
//                padding digit used to force a null vote on short entries.
//  Revision    : 1.0 - initial release
// ============================================================================
package urna_pkg;

    localparam int DIG_W       = 4;
    localparam int NUM_DIGITOS = 4;
    // Enough bits to hold the count 0..NUM_DIGITOS
    localparam int CNT_DIG_W   = 3;

    // Never a valid candidate digit: short entries are recorded as null
    localparam logic [DIG_W-1:0] DIGITO_INVALIDO = 4'hF;

    typedef enum logic [1:0] {
        LIVRE     = 2'd0,
        DIGITANDO = 2'd1,
        ENVIANDO  = 2'd2,
        AGUARDA   = 2'd3
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/urna_buffer_digitos.sv
`default_nettype none
// ============================================================================
//  Module      : urna_buffer_digitos
//  Description : 4 x 4-bit digit buffer with write pointer.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                i_clear       - empty the buffer (count and slots to 0)
//                i_write       - store i_data at slot o_count if not full
//                i_pad         - fill every unwritten slot with the pad digit
//                i_rd_idx      - combinational read index -> o_rd_data
//                o_count       - number of digits stored, 0..NUM_DIGITOS
//  Revision    : 1.0 - initial release
// ============================================================================
module urna_buffer_digitos
    import urna_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_write,
    input  logic [DIG_W-1:0]     i_data,
    input  logic                 i_pad,
    input  logic [1:0]           i_rd_idx,
    output logic [CNT_DIG_W-1:0] o_count,
    output logic [DIG_W-1:0]     o_rd_data
);

    logic [DIG_W-1:0]     r_mem [NUM_DIGITOS];
    logic [CNT_DIG_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITOS; i++) r_mem[i] <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < NUM_DIGITOS; i++) r_mem[i] <= '0;
            r_count <= '0;
        end else if (i_pad) begin
            // Count is kept: it still reports how many digits were keyed
            for (int i = 0; i < NUM_DIGITOS; i++) begin
                if (CNT_DIG_W'(i) >= r_count) r_mem[i] <= DIGITO_INVALIDO;
            end
        end else if (i_write && (r_count < CNT_DIG_W'(NUM_DIGITOS))) begin
            r_mem[r_count[1:0]] <= i_data;
            r_count             <= r_count + CNT_DIG_W'(1);
        end
    end

    assign o_count   = r_count;
    assign o_rd_data = r_mem[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/urna_sessao_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : urna_sessao_ctrl
//  Description : Voter-session sequencer between keypad/poll-worker panel and
//                the vote-counting FSM. Opens a session on Libera, buffers up
//                to 4 digits (Corrige/Confirma), replays them as single-cycle
//                Valid_Out strobes, then waits for Status_In.
//  Ports       : Clock, Reset (async, active-high)
//                Libera, Key_Valid, Key_Code, Corrige, Confirma - panel inputs
//                Status_In  - vote registered, from the vote FSM
//                Digit_Out, Valid_Out (registered), Finish_Out (comb.)
//                Pronta, Num_Digitos, Eleitores, Timeout_Evt, Erro_Status
//  Revision    : 1.0 - initial release
// ============================================================================
module urna_sessao_ctrl
    import urna_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int STATUS_WAIT    = 4,
    parameter int CNT_W          = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Libera,
    input  logic                 Key_Valid,
    input  logic [DIG_W-1:0]     Key_Code,
    input  logic                 Corrige,
    input  logic                 Confirma,
    input  logic                 Status_In,
    output logic [DIG_W-1:0]     Digit_Out,
    output logic                 Valid_Out,
    output logic                 Finish_Out,
    output logic                 Pronta,
    output logic [CNT_DIG_W-1:0] Num_Digitos,
    output logic [CNT_W-1:0]     Eleitores,
    output logic                 Timeout_Evt,
    output logic                 Erro_Status
);

    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WAIT_W = $clog2(STATUS_WAIT + 1);

    estado_t           r_state, w_next;
    logic [TMR_W-1:0]  r_timer;
    logic [WAIT_W-1:0] r_wait;
    logic [1:0]        r_idx;

    logic             w_act, w_buf_clear, w_buf_write, w_buf_pad;
    logic             w_inc_votos, w_timeout, w_erro;
    logic [DIG_W-1:0] w_rd_data;

    assign w_act = Corrige | Confirma | Key_Valid;

    urna_buffer_digitos u_buffer (
        .clk       (Clock),
        .rst       (Reset),
        .i_clear   (w_buf_clear),
        .i_write   (w_buf_write),
        .i_data    (Key_Code),
        .i_pad     (w_buf_pad),
        .i_rd_idx  (r_idx),
        .o_count   (Num_Digitos),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) r_state <= LIVRE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_buf_clear = 1'b0;
        w_buf_write = 1'b0;
        w_buf_pad   = 1'b0;
        w_inc_votos = 1'b0;
        w_timeout   = 1'b0;
        w_erro      = 1'b0;
        Finish_Out  = 1'b1;
        case (r_state)
            LIVRE: begin
                if (Libera) begin
                    w_next      = DIGITANDO;
                    w_buf_clear = 1'b1;
                end
            end
            DIGITANDO: begin
                // A digit keyed together with Corrige/Confirma is dropped
                if (Corrige) begin
                    w_buf_clear = 1'b1;
                end else if (Confirma) begin
                    if (Num_Digitos != '0) begin
                        w_buf_pad = 1'b1;
                        w_next    = ENVIANDO;
                    end
                end else if (Key_Valid) begin
                    w_buf_write = 1'b1;
                end
                if (!w_act && (r_timer == TMR_W'(TIMEOUT_CYCLES - 1))) begin
                    w_timeout = 1'b1;
                    w_next    = LIVRE;
                end
            end
            ENVIANDO: begin
                // Release the vote FSM in the same cycle it reports Status
                Finish_Out = Status_In;
                if (Status_In) begin
                    w_inc_votos = 1'b1;
                    w_next      = LIVRE;
                end else if (r_idx == 2'd3) begin
                    w_next = AGUARDA;
                end
            end
            AGUARDA: begin
                Finish_Out = Status_In;
                if (Status_In) begin
                    w_inc_votos = 1'b1;
                    w_next      = LIVRE;
                end else if (r_wait == WAIT_W'(STATUS_WAIT - 1)) begin
                    w_erro = 1'b1;
                    w_next = LIVRE;
                end
            end
            default: w_next = LIVRE;
        endcase
    end

    assign Pronta = (r_state == DIGITANDO);

    // Inactivity timer: runs only in DIGITANDO, restarted by any panel input
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)                             r_timer <= '0;
        else if (r_state != DIGITANDO || w_act) r_timer <= '0;
        else                                   r_timer <= r_timer + TMR_W'(1);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_idx  <= '0;
            r_wait <= '0;
        end else begin
            r_idx  <= (r_state == ENVIANDO) ? r_idx + 2'd1 : 2'd0;
            r_wait <= (r_state == AGUARDA) ? r_wait + WAIT_W'(1) : '0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Digit_Out   <= '0;
            Valid_Out   <= 1'b0;
            Eleitores   <= '0;
            Timeout_Evt <= 1'b0;
            Erro_Status <= 1'b0;
        end else begin
            // An early Status stops the replay from the next cycle on
            Valid_Out   <= (r_state == ENVIANDO) && !Status_In;
            if (r_state == ENVIANDO) Digit_Out <= w_rd_data;
            Timeout_Evt <= w_timeout;
            if (w_erro) Erro_Status <= 1'b1;
            if (w_inc_votos && (Eleitores != '1)) Eleitores <= Eleitores + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_urna_sessao_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_urna_sessao_ctrl
//  Description : Self-checking bench for urna_sessao_ctrl with a small
//                behavioural model (digit queue + vote count) and a vote-FSM
//                responder. Counter narrowed to 3 bits to reach saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_urna_sessao_ctrl;

    localparam int TO = 8;
    localparam int SW = 4;
    localparam int CW = 3;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Libera = 1'b0, Key_Valid = 1'b0, Corrige = 1'b0;
    logic          Confirma = 1'b0, Status_In = 1'b0;
    logic [3:0]    Key_Code = 4'd0;
    logic [3:0]    Digit_Out;
    logic          Valid_Out, Finish_Out, Pronta, Timeout_Evt, Erro_Status;
    logic [2:0]    Num_Digitos;
    logic [CW-1:0] Eleitores;

    int checks = 0;
    int errors = 0;

    // Model state: digits that should be in the buffer, completed votes
    logic [3:0] mbuf[$];
    int         exp_votes = 0;
    // Digits seen by the vote FSM
    logic [3:0] got[$];

    urna_sessao_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .STATUS_WAIT    (SW),
        .CNT_W          (CW)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Libera      (Libera),
        .Key_Valid   (Key_Valid),
        .Key_Code    (Key_Code),
        .Corrige     (Corrige),
        .Confirma    (Confirma),
        .Status_In   (Status_In),
        .Digit_Out   (Digit_Out),
        .Valid_Out   (Valid_Out),
        .Finish_Out  (Finish_Out),
        .Pronta      (Pronta),
        .Num_Digitos (Num_Digitos),
        .Eleitores   (Eleitores),
        .Timeout_Evt (Timeout_Evt),
        .Erro_Status (Erro_Status)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) if (Valid_Out === 1'b1) got.push_back(Digit_Out);

    function automatic logic [3:0] exp_digit(input int i);
        return (i < mbuf.size()) ? mbuf[i] : 4'hF;
    endfunction

    function automatic logic [CW-1:0] exp_el();
        return (exp_votes >= (1 << CW) - 1) ? {CW{1'b1}} : CW'(exp_votes);
    endfunction

    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_libera();
        Libera = 1'b1; cycle(); Libera = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        Key_Valid = 1'b1; Key_Code = d; cycle(); Key_Valid = 1'b0;
        if (mbuf.size() < 4) mbuf.push_back(d);
    endtask

    task automatic corrige();
        Corrige = 1'b1; cycle(); Corrige = 1'b0;
        mbuf.delete();
    endtask

    task automatic confirma();
        got.delete();
        Confirma = 1'b1; cycle(); Confirma = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) cycle();
        checks += 8;
        if (Pronta !== 1'b0)      begin errors++; $display("FAIL reset_pronta got %b exp 0", Pronta); end
        if (Num_Digitos !== 3'd0) begin errors++; $display("FAIL reset_num got %0d exp 0", Num_Digitos); end
        if (Digit_Out !== 4'd0)   begin errors++; $display("FAIL reset_digit got %h exp 0", Digit_Out); end
        if (Valid_Out !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b exp 0", Valid_Out); end
        if (Finish_Out !== 1'b1)  begin errors++; $display("FAIL reset_finish got %b exp 1", Finish_Out); end
        if (Eleitores !== '0)     begin errors++; $display("FAIL reset_eleitores got %0d exp 0", Eleitores); end
        if (Timeout_Evt !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", Timeout_Evt); end
        if (Erro_Status !== 1'b0) begin errors++; $display("FAIL reset_erro got %b exp 0", Erro_Status); end
        Reset = 1'b0;
        cycle();
    endtask

    task automatic test_happy();
        mbuf.delete();
        do_libera();
        checks++;
        if (Pronta !== 1'b1) begin errors++; $display("FAIL happy_pronta got %b exp 1", Pronta); end
        key(4'd3); key(4'd4); key(4'd9); key(4'd4);
        confirma();
        checks++;
        if (Finish_Out !== 1'b0) begin errors++; $display("FAIL happy_finish_enviando got %b exp 0", Finish_Out); end
        repeat (5) cycle();
        Status_In = 1'b1;
        #1;
        checks += 2;
        if (Finish_Out !== 1'b1) begin errors++; $display("FAIL happy_finish_status got %b exp 1", Finish_Out); end
        if (Valid_Out !== 1'b0)  begin errors++; $display("FAIL happy_valid_aguarda got %b exp 0", Valid_Out); end
        cycle();
        Status_In = 1'b0;
        exp_votes++;
        checks += 3;
        if (got.size() != 4)      begin errors++; $display("FAIL happy_valid_len got %0d exp 4", got.size()); end
        if (Eleitores !== exp_el()) begin errors++; $display("FAIL happy_eleitores got %0d exp %0d", Eleitores, exp_el()); end
        if (Pronta !== 1'b0)      begin errors++; $display("FAIL happy_livre got %b exp 0", Pronta); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp_digit(i)) begin errors++; $display("FAIL happy_digit%0d got %h exp %h", i, got[i], exp_digit(i)); end
        end
    endtask

    task automatic test_short_null();
        mbuf.delete();
        do_libera();
        key(4'd3); key(4'd4);
        confirma();
        cycle(); cycle(); cycle();
        // Vote FSM sees the pad digit and reports the null vote immediately
        checks += 2;
        if (Digit_Out !== 4'hF || Valid_Out !== 1'b1) begin
            errors++; $display("FAIL short_pad got %h/%b exp f/1", Digit_Out, Valid_Out);
        end
        Status_In = 1'b1;
        #1;
        if (Finish_Out !== 1'b1) begin errors++; $display("FAIL short_finish got %b exp 1", Finish_Out); end
        cycle();
        Status_In = 1'b0;
        exp_votes++;
        checks += 3;
        if (Valid_Out !== 1'b0)     begin errors++; $display("FAIL short_valid_drop got %b exp 0", Valid_Out); end
        if (Eleitores !== exp_el()) begin errors++; $display("FAIL short_eleitores got %0d exp %0d", Eleitores, exp_el()); end
        if (got.size() != 3)        begin errors++; $display("FAIL short_len got %0d exp 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== exp_digit(i)) begin errors++; $display("FAIL short_digit%0d got %h exp %h", i, got[i], exp_digit(i)); end
        end
        cycle();
    endtask

    task automatic test_correct_overflow();
        mbuf.delete();
        do_libera();
        key(4'd7); key(4'd7);
        corrige();
        checks++;
        if (Num_Digitos !== 3'd0) begin errors++; $display("FAIL corrige_num got %0d exp 0", Num_Digitos); end
        key(4'd3); key(4'd5); key(4'd0); key(4'd4); key(4'd9);
        checks++;
        if (Num_Digitos !== 3'(mbuf.size())) begin errors++; $display("FAIL overflow_num got %0d exp %0d", Num_Digitos, mbuf.size()); end
        confirma();
        repeat (5) cycle();
        Status_In = 1'b1; cycle(); Status_In = 1'b0;
        exp_votes++;
        checks += 2;
        if (got.size() != 4)        begin errors++; $display("FAIL overflow_len got %0d exp 4", got.size()); end
        if (Eleitores !== exp_el()) begin errors++; $display("FAIL overflow_eleitores got %0d exp %0d", Eleitores, exp_el()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp_digit(i)) begin errors++; $display("FAIL overflow_digit%0d got %h exp %h", i, got[i], exp_digit(i)); end
        end
    endtask

    task automatic test_timeout();
        int n_pronta = 0, n_to = 0, to_at = -1, n_valid = 0, n_fin_low = 0;
        do_libera();
        for (int i = 0; i < 20; i++) begin
            if (Pronta === 1'b1) n_pronta++;
            if (Timeout_Evt === 1'b1) begin n_to++; to_at = i; end
            if (Valid_Out !== 1'b0) n_valid++;
            if (Finish_Out !== 1'b1) n_fin_low++;
            cycle();
        end
        checks += 6;
        if (n_pronta != TO)  begin errors++; $display("FAIL timeout_pronta_cycles got %0d exp %0d", n_pronta, TO); end
        if (n_to != 1)       begin errors++; $display("FAIL timeout_pulses got %0d exp 1", n_to); end
        if (to_at != TO)     begin errors++; $display("FAIL timeout_position got %0d exp %0d", to_at, TO); end
        if (n_valid != 0)    begin errors++; $display("FAIL timeout_valid got %0d exp 0", n_valid); end
        if (n_fin_low != 0)  begin errors++; $display("FAIL timeout_finish_low got %0d exp 0", n_fin_low); end
        if (Eleitores !== exp_el()) begin errors++; $display("FAIL timeout_eleitores got %0d exp %0d", Eleitores, exp_el()); end
    endtask

    task automatic test_status_missing_reset();
        mbuf.delete();
        do_libera();
        key(4'd1);
        confirma();
        repeat (7) cycle();
        checks += 2;
        if (Erro_Status !== 1'b0) begin errors++; $display("FAIL erro_early got %b exp 0", Erro_Status); end
        if (Finish_Out !== 1'b0)  begin errors++; $display("FAIL erro_finish_aguarda got %b exp 0", Finish_Out); end
        cycle();
        checks += 3;
        if (Erro_Status !== 1'b1)   begin errors++; $display("FAIL erro_set got %b exp 1", Erro_Status); end
        if (Pronta !== 1'b0)        begin errors++; $display("FAIL erro_livre got %b exp 0", Pronta); end
        if (Eleitores !== exp_el()) begin errors++; $display("FAIL erro_eleitores got %0d exp %0d", Eleitores, exp_el()); end
        mbuf.delete();
        do_libera();
        key(4'd5); key(4'd6);
        checks += 2;
        if (Erro_Status !== 1'b1) begin errors++; $display("FAIL erro_sticky got %b exp 1", Erro_Status); end
        if (Num_Digitos !== 3'd2) begin errors++; $display("FAIL prereset_num got %0d exp 2", Num_Digitos); end
        #2 Reset = 1'b1;
        #1;
        exp_votes = 0;
        mbuf.delete();
        checks += 6;
        if (Pronta !== 1'b0)        begin errors++; $display("FAIL areset_pronta got %b exp 0", Pronta); end
        if (Num_Digitos !== 3'd0)   begin errors++; $display("FAIL areset_num got %0d exp 0", Num_Digitos); end
        if (Erro_Status !== 1'b0)   begin errors++; $display("FAIL areset_erro got %b exp 0", Erro_Status); end
        if (Eleitores !== '0)       begin errors++; $display("FAIL areset_eleitores got %0d exp 0", Eleitores); end
        if (Finish_Out !== 1'b1)    begin errors++; $display("FAIL areset_finish got %b exp 1", Finish_Out); end
        if (Valid_Out !== 1'b0 || Digit_Out !== 4'd0 || Timeout_Evt !== 1'b0) begin
            errors++; $display("FAIL areset_outs got %b/%h/%b exp 0/0/0", Valid_Out, Digit_Out, Timeout_Evt);
        end
        #1 Reset = 1'b0;
        cycle();
    endtask

    task automatic test_libera_ignored();
        mbuf.delete();
        do_libera();
        key(4'd2); key(4'd8);
        got.delete();
        Confirma = 1'b1; Key_Valid = 1'b1; Key_Code = 4'd6;
        cycle();
        Confirma = 1'b0; Key_Valid = 1'b0;
        checks++;
        if (Num_Digitos !== 3'd2) begin errors++; $display("FAIL confkey_num got %0d exp 2", Num_Digitos); end
        Libera = 1'b1; cycle(); Libera = 1'b0;
        repeat (4) cycle();
        Status_In = 1'b1; cycle(); Status_In = 1'b0;
        exp_votes++;
        checks += 2;
        if (got.size() != 4)        begin errors++; $display("FAIL confkey_len got %0d exp 4", got.size()); end
        if (Eleitores !== exp_el()) begin errors++; $display("FAIL confkey_eleitores got %0d exp %0d", Eleitores, exp_el()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp_digit(i)) begin errors++; $display("FAIL confkey_digit%0d got %h exp %h", i, got[i], exp_digit(i)); end
        end
        cycle(); cycle();
        checks++;
        if (Pronta !== 1'b0) begin errors++; $display("FAIL libera_not_queued got %b exp 0", Pronta); end
    endtask

    task automatic test_random_sessions();
        for (int s = 0; s < 20; s++) begin
            int nact, dly;
            mbuf.delete();
            do_libera();
            nact = $urandom_range(0, 7);
            for (int a = 0; a < nact; a++) begin
                if ($urandom_range(0, 9) == 0) corrige();
                else key(4'($urandom_range(0, 15)));
                repeat ($urandom_range(0, 3)) cycle();
            end
            checks++;
            if (Num_Digitos !== 3'(mbuf.size())) begin errors++; $display("FAIL rand%0d_num got %0d exp %0d", s, Num_Digitos, mbuf.size()); end
            if (mbuf.size() == 0) begin
                confirma();
                checks++;
                if (Pronta !== 1'b1) begin errors++; $display("FAIL rand%0d_empty_confirm got %b exp 1", s, Pronta); end
                key(4'($urandom_range(0, 15)));
            end
            confirma();
            dly = $urandom_range(0, SW - 2);
            repeat (5 + dly) cycle();
            Status_In = 1'b1; cycle(); Status_In = 1'b0;
            exp_votes++;
            checks += 3;
            if (got.size() != 4)        begin errors++; $display("FAIL rand%0d_len got %0d exp 4", s, got.size()); end
            if (Eleitores !== exp_el()) begin errors++; $display("FAIL rand%0d_eleitores got %0d exp %0d", s, Eleitores, exp_el()); end
            if (Erro_Status !== 1'b0)   begin errors++; $display("FAIL rand%0d_erro got %b exp 0", s, Erro_Status); end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp_digit(i)) begin errors++; $display("FAIL rand%0d_digit%0d got %h exp %h", s, i, got[i], exp_digit(i)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_happy();
        test_short_null();
        test_correct_overflow();
        test_timeout();
        test_status_missing_reset();
        test_libera_ignored();
        test_random_sessions();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/urna_sessao_ctrl.md
Name: urna_sessao_ctrl

Overview:
- Voter-session sequencer placed between the keypad/poll-worker panel and the vote-counting FSM.
- Holds the vote FSM idle between voters. Opens one session per poll-worker authorisation and buffers up to 4 keyed digits, with correct/confirm support.
- On confirm, replays the buffered digits to the vote FSM as single-cycle Valid strobes, waits for its Status, then returns it to idle.
- Also provides an inactivity timeout and a voter count.

Parameters:
- TIMEOUT_CYCLES, 50_000_000: idle cycles allowed in DIGITANDO before the session is aborted.
- STATUS_WAIT, 4: cycles allowed in AGUARDA for Status_In before the error flag is set.
- CNT_W, 8: width of the Eleitores counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Libera  in  1  poll-worker authorisation pulse.
- Key_Valid  in  1  one-cycle keypad digit strobe.
- Key_Code  in  4  digit value, sampled when Key_Valid=1.
- Corrige  in  1  clear-buffer pulse.
- Confirma  in  1  confirm-vote pulse.
- Status_In  in  1  vote-registered flag from the vote FSM.
- Digit_Out  out  4  digit to the vote FSM (registered).
- Valid_Out  out  1  digit strobe to the vote FSM (registered).
- Finish_Out  out  1  hold/return-to-idle to the vote FSM (combinational).
- Pronta  out  1  session open (state DIGITANDO).
- Num_Digitos  out  3  digits currently buffered, 0..4.
- Eleitores  out  CNT_W  completed-vote count, saturating.
- Timeout_Evt  out  1  one-cycle pulse on session timeout.
- Erro_Status  out  1  sticky flag: Status_In missing; cleared only by Reset.

Behaviour:
- Reset (asynchronous, any state, mid-replay included):
  - state=LIVRE; buffer, Num_Digitos, replay index, timers = 0.
  - Digit_Out=0, Valid_Out=0, Eleitores=0, Timeout_Evt=0, Erro_Status=0.
  - Finish_Out=1.
- Finish_Out = 1 in LIVRE and DIGITANDO; = Status_In in ENVIANDO and AGUARDA. It is combinational so the vote FSM is released in the same cycle Status is seen, which prevents a repeated null increment.
- LIVRE:
  - Libera=1 -> DIGITANDO; buffer cleared, timer cleared.
  - All keypad inputs are ignored.
- DIGITANDO, per cycle, priority Corrige > Confirma > Key_Valid:
  - Corrige: clear buffer, Num_Digitos=0.
  - Confirma with Num_Digitos=0: ignored.
  - Confirma with Num_Digitos>=1: pad empty slots with 4'hF (always invalid, so a short entry is recorded as null), index=0 -> ENVIANDO.
  - Key_Valid with Num_Digitos<4: store Key_Code at slot Num_Digitos, increment Num_Digitos.
  - Key_Valid with Num_Digitos=4: digit dropped.
  - A Key_Valid arriving in the same cycle as Corrige or Confirma is dropped.
  - Any of the three inputs resets the inactivity timer.
  - Timer reaches TIMEOUT_CYCLES-1 -> Timeout_Evt=1 for one cycle, -> LIVRE. No digits are sent and Eleitores is unchanged.
- ENVIANDO (4 cycles, one digit per cycle):
  - Each cycle registers Digit_Out=buffer[index] and Valid_Out=1.
  - After index 3 -> AGUARDA.
  - If Status_In=1 (early null): Eleitores += 1, -> LIVRE, Valid_Out=0 from the next cycle.
- AGUARDA:
  - Valid_Out=0.
  - Status_In=1: Eleitores += 1 (saturates at all-ones), -> LIVRE.
  - STATUS_WAIT cycles without Status_In: Erro_Status=1, -> LIVRE, Eleitores unchanged.
- Libera outside LIVRE is ignored. Libera is not queued.
- Registered outputs change only on the Clock edge.
- Happy-path latency: Confirma at edge n -> Valid_Out high in cycles n+1..n+4 -> Status_In visible at n+5 -> Finish_Out=1 in cycle n+5 -> LIVRE at n+6.

Decomposition:
- Shared package urna_pkg holds:
  - state encoding LIVRE/DIGITANDO/ENVIANDO/AGUARDA;
  - DIGITO_INVALIDO = 4'hF;
  - NUM_DIGITOS = 4;
  - digit width 4.
- One sub-module: urna_buffer_digitos, a 4x4-bit buffer with write pointer, clear, pad-with-F and read-index port.
- Timers and the state machine stay in the top module.

Test Plan:
- Libera; keys 3,4,9,4; Confirma; model answers Status_In=1 five cycles after Confirma -> Digit_Out sequence 3,4,9,4 with Valid_Out high exactly 4 cycles; Finish_Out=1 in the Status cycle; Eleitores=1; state LIVRE.
- Libera; keys 3,4; Confirma -> Digit_Out sequence 3,4,F,F; vote FSM reaches null and raises Status mid-replay -> Valid_Out drops the next cycle; Eleitores += 1.
- Libera; keys 7,7; Corrige; keys 3,5,0,4,9 -> Num_Digitos=4; the fifth digit (9) is dropped; replay is 3,5,0,4.
- Libera; no key for TIMEOUT_CYCLES (8 in the bench) -> Timeout_Evt pulses once; Valid_Out never asserted; Eleitores unchanged; Finish_Out stays 1.
- Confirma with Status_In tied 0 -> Erro_Status=1 after STATUS_WAIT cycles in AGUARDA; then assert Reset mid-DIGITANDO of the next session -> all outputs return to their reset values immediately.
- Libera during ENVIANDO, and Confirma+Key_Valid in the same cycle -> Libera ignored; the keyed digit is not buffered.
